// File: rtl/aes_inv_round_sched.sv
// Round scheduler for the shared AES inverse-cipher datapath: walks one tagged
// block through the 4*NUM_ROUNDS op sequence, one op_start/op_done handshake per op.
module aes_inv_round_sched #(
  parameter int NUM_ROUNDS = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       in_valid,
  input  logic [3:0] in_tag,
  output logic       in_ready,
  output logic       op_start,
  output logic [1:0] op_code,
  output logic [3:0] key_idx,
  input  logic       op_done,
  input  logic       abort,
  output logic       out_valid,
  output logic [3:0] out_tag,
  input  logic       out_ready,
  output logic       err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_ADDKEY    = 2'd0;
  localparam logic [1:0] OP_INV_SHIFT = 2'd1;
  localparam logic [1:0] OP_INV_SUB   = 2'd2;
  localparam logic [1:0] OP_INV_MIX   = 2'd3;

  localparam logic [3:0]    KEY_FIRST  = 4'(NUM_ROUNDS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [3:0]    key_q, key_d;
  logic [3:0]    tag_q, tag_d;
  logic [TW-1:0] timer_q, timer_d;

  // The only ADDKEY carrying key NUM_ROUNDS is the opening whitening step,
  // which goes straight into InvShiftRows; every later ADDKEY is followed by InvMixColumns.
  function automatic logic [1:0] next_op(input logic [1:0] op, input logic [3:0] key);
    case (op)
      OP_ADDKEY:    next_op = (key == KEY_FIRST) ? OP_INV_SHIFT : OP_INV_MIX;
      OP_INV_SHIFT: next_op = OP_INV_SUB;
      OP_INV_SUB:   next_op = OP_ADDKEY;
      default:      next_op = OP_INV_SHIFT;
    endcase
  endfunction

  function automatic logic is_last_op(input logic [1:0] op, input logic [3:0] key);
    is_last_op = (op == OP_ADDKEY) && (key == 4'd0);
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADDKEY;
      key_q   <= 4'd0;
      tag_q   <= 4'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      key_q   <= key_d;
      tag_q   <= tag_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    key_d   = key_q;
    tag_d   = tag_q;
    timer_d = timer_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && (in_tag != 4'd0)) begin
          tag_d   = in_tag;
          key_d   = KEY_FIRST;
          op_d    = OP_ADDKEY;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (op_done) begin
          if (is_last_op(op_q, key_q)) begin
            state_d = S_DONE;
          end else begin
            op_d    = next_op(op_q, key_q);
            state_d = S_ISSUE;
            if (op_q == OP_ADDKEY) begin
              key_d = key_q - 4'd1;
            end
          end
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_q == TIMER_LAST) begin
            state_d = S_ERR;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      tag_d   = 4'd0;
    end
  end

  // Moore outputs; abort suppresses the pulses in the cycle it is seen.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    op_start  = (state_q == S_ISSUE) && !abort;
    out_valid = (state_q == S_DONE) && !abort;
    err       = (state_q == S_ERR) && !abort;
    out_tag   = (state_q == S_DONE) ? tag_q : 4'd0;
    op_code   = op_q;
    key_idx   = key_q;
  end

endmodule
